demux12_stream: RTL and testbench



---
 rtl/demux12_stream.sv | 121 ++++++++++++
 tb/tb_demux12_stream.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux12_stream.sv
// demux12_stream: registered 1-to-2 valid/ready stream demultiplexer; the packet destination is locked on the first beat.
// Optional packet counters and sticky sel_err are present only when DEMUX12_STATS_EN is defined.
module demux12_stream #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DEMUX12_STATS_EN
    output logic [15:0]      pkt_cnt_a,
    output logic [15:0]      pkt_cnt_b,
    output logic [0:0]       sel_err,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_last,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t state;
    logic   dest;
    logic   a_free;
    logic   b_free;
    logic   accept;

    // In IDLE the beat chooses its own sink; mid-packet the lock wins and in_sel is ignored.
    always_comb begin
        // NOTE: default assignment first so every path drives dest and no latch is inferred.
        dest = in_sel;
        if (state == LOCK_A) begin
            dest = 1'b0;
        end else if (state == LOCK_B) begin
            dest = 1'b1;
        end
    end

    assign a_free   = !a_valid || a_ready;
    assign b_free   = !b_valid || b_ready;
    assign in_ready = dest ? b_free : a_free;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
            state   <= IDLE;
            a_valid <= 1'b0;
            a_data  <= '0;
            a_last  <= 1'b0;
            b_valid <= 1'b0;
            b_data  <= '0;
            b_last  <= 1'b0;
        end else begin
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (!in_last) begin
                            state <= in_sel ? LOCK_B : LOCK_A;
                        end
                    end
                    default: begin
                        if (in_last) begin
                            state <= IDLE;
                        end
                    end
                endcase
            end

            // A refill takes priority over a drain so a slot can stream one word per cycle.
            if (accept && !dest) begin
                a_valid <= 1'b1;
                a_data  <= in_data;
                a_last  <= in_last;
            end else if (a_ready) begin
                a_valid <= 1'b0;
            end

            if (accept && dest) begin
                b_valid <= 1'b1;
                b_data  <= in_data;
                b_last  <= in_last;
            end else if (b_ready) begin
                b_valid <= 1'b0;
            end
        end
    end

`ifdef DEMUX12_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_a <= '0;
            pkt_cnt_b <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (a_valid && a_ready && a_last) begin
                pkt_cnt_a <= pkt_cnt_a + 16'd1;
            end
            if (b_valid && b_ready && b_last) begin
                pkt_cnt_b <= pkt_cnt_b + 16'd1;
            end
            if (accept && (state != IDLE) && (in_sel != dest)) begin
                sel_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux12_stream.sv
// Self-checking bench for demux12_stream: per-sink expected-word queues filled by the driver, drained by a monitor.
// Packet destination in the model is simply the sel of the packet's first beat.
module tb_demux12_stream;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_sel;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] a_data;
    logic         a_last;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] b_data;
    logic         b_last;
`ifdef DEMUX12_STATS_EN
    logic [15:0]  pkt_cnt_a;
    logic [15:0]  pkt_cnt_b;
    logic [0:0]   sel_err;
`endif

    demux12_stream #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef DEMUX12_STATS_EN
        .pkt_cnt_a(pkt_cnt_a),
        .pkt_cnt_b(pkt_cnt_b),
        .sel_err  (sel_err),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .in_last  (in_last),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_last   (a_last),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_last   (b_last)
    );

    always #5 clk = ~clk;

    beat_t exp_a[$];
    beat_t exp_b[$];
    int    checks   = 0;
    int    failures = 0;
    int    pkts_a   = 0;
    int    pkts_b   = 0;
    bit    rand_done;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Offer one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic sel, input logic [W-1:0] data, input logic last);
        bit done = 1'b0;
        int n    = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n >= 500) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=no_accept expected=accept at t=%0t", $time);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic sel, input int nbeats, input bit toggle);
        for (int i = 0; i < nbeats; i++) begin
            beat_t bt;
            logic  s;
            bt.data = {$urandom, $urandom};
            bt.last = (i == nbeats - 1);
            if (i == 0)   s = sel;
            else if (toggle) s = ~sel;
            else          s = 1'($urandom_range(0, 1));
            if (sel) exp_b.push_back(bt);
            else     exp_a.push_back(bt);
            send_beat(s, bt.data, bt.last);
            if (!toggle && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        if (sel) pkts_b++;
        else     pkts_a++;
    endtask

    // Monitor: pops expected words on every transfer and checks slot stability under backpressure.
    beat_t        ea;
    beat_t        eb;
    bit           a_stall = 1'b0;
    bit           b_stall = 1'b0;
    logic [W:0]   a_held;
    logic [W:0]   b_held;

    always @(negedge clk) begin
        if (rst) begin
            a_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (a_stall) begin
                check("a_hold_valid", a_valid, 1);
                check("a_hold_word", {a_data, a_last}, a_held);
            end
            if (b_stall) begin
                check("b_hold_valid", b_valid, 1);
                check("b_hold_word", {b_data, b_last}, b_held);
            end
            if (a_valid && a_ready) begin
                check("a_word_expected", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) begin
                    ea = exp_a.pop_front();
                    check("a_word", {a_data, a_last}, ea);
                end
            end
            if (b_valid && b_ready) begin
                check("b_word_expected", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) begin
                    eb = exp_b.pop_front();
                    check("b_word", {b_data, b_last}, eb);
                end
            end
            a_stall = a_valid && !a_ready;
            b_stall = b_valid && !b_ready;
            a_held  = {a_data, a_last};
            b_held  = {b_data, b_last};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        beat_t        tb_b;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        int           n;

        // Reset with in_valid asserted: nothing may be captured.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = {$urandom, $urandom};
        in_last  = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_valid", a_valid, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_a_word", {a_data, a_last}, 0);
        check("rst_b_word", {b_data, b_last}, 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_a_valid", a_valid, 0);
        check("post_rst_b_valid", b_valid, 0);
`ifdef DEMUX12_STATS_EN
        check("post_rst_sel_err", sel_err, 0);
        check("post_rst_pkt_cnt", {pkt_cnt_a, pkt_cnt_b}, 0);
`endif

        // Single-beat packet to B, one-cycle latency.
        @(posedge clk);
        #1;
        b_ready = 1'b1;
        tb_b.data = 64'hDEADBEEF00000001;
        tb_b.last = 1'b1;
        exp_b.push_back(tb_b);
        send_beat(1'b1, tb_b.data, 1'b1);
        pkts_b++;
        check("single_b_valid", b_valid, 1);
        check("single_b_word", {b_data, b_last}, {64'hDEADBEEF00000001, 1'b1});
        check("single_a_valid", a_valid, 0);
        a_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Lock: sel flips after the first beat, all three words must stay on A.
        send_pkt(1'b0, 3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("lock_a_idle", a_valid, 0);
`ifdef DEMUX12_STATS_EN
        check("lock_sel_err", sel_err, 1);
        check("lock_pkt_cnt_a", pkt_cnt_a, 1);
        check("lock_pkt_cnt_b", pkt_cnt_b, 1);
`endif

        // Backpressure on A: second beat must wait while the first is held.
        a_ready = 1'b0;
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        tb_b.data = d1;
        tb_b.last = 1'b0;
        exp_a.push_back(tb_b);
        send_beat(1'b0, d1, 1'b0);
        check("bp_a_valid", a_valid, 1);
        check("bp_a_word", {a_data, a_last}, {d1, 1'b0});
        tb_b.data = d2;
        tb_b.last = 1'b1;
        exp_a.push_back(tb_b);
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = d2;
        in_last  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_held_data", a_data, d1);
            @(posedge clk);
            #1;
        end
        a_ready = 1'b1;
        send_beat(1'b1, d2, 1'b1);
        pkts_a++;
        repeat (3) @(posedge clk);
        #1;
        check("bp_drained", exp_a.size(), 0);

        // Throughput: eight back-to-back beats to B.
        b_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tb_b.data = {$urandom, $urandom};
            tb_b.last = (i == 7);
            exp_b.push_back(tb_b);
            in_valid = 1'b1;
            in_sel   = 1'b1;
            in_data  = tb_b.data;
            in_last  = tb_b.last;
            @(negedge clk);
            check("thru_in_ready", in_ready, 1);
            if (i > 0) check("thru_b_valid", b_valid, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        pkts_b++;
        @(negedge clk);
        check("thru_b_valid_last", b_valid, 1);
        @(negedge clk);
        check("thru_b_idle", b_valid, 0);
        @(posedge clk);
        #1;

        // Random packets with random sink backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 200; p++) begin
                    send_pkt(1'($urandom_range(0, 1)), $urandom_range(1, 4), 1'b0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    a_ready = ($urandom_range(0, 3) != 0);
                    b_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        a_ready = 1'b1;
        b_ready = 1'b1;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("final_a_empty", exp_a.size(), 0);
        check("final_b_empty", exp_b.size(), 0);
        check("final_a_idle", a_valid, 0);
        check("final_b_idle", b_valid, 0);
`ifdef DEMUX12_STATS_EN
        check("final_pkt_cnt_a", pkt_cnt_a, pkts_a[15:0]);
        check("final_pkt_cnt_b", pkt_cnt_b, pkts_b[15:0]);
        check("final_pkt_total", 32'(pkt_cnt_a) + 32'(pkt_cnt_b), pkts_a + pkts_b);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
